demo_sequencer: RTL and testbench
=================================

# demo_sequencer

Frame-rate show controller for the VGA/audio demo. It sits directly upstream of the effect renderer and audio voices. It counts frames from the sync generator's frame tick, steps through a ROM-defined list of visual parts with brightness fade-out/fade-in at each boundary, and derives the music timing signals (note index, decay envelopes, snare-beat gate) from a global frame counter. All state outputs are registered; the renderer reads `part`, `part_frame` and `brightness`, and the audio voices read `note_idx`, `env_a`, `env_b` and `beat13`.

## Interface
- `UNIT_LOG2`, 5: part-length unit is 2^UNIT_LOG2 frames.
- `FADE_STEP`, 2: frames per brightness step.
- `LOOP_PART`, 1: part entered after part 7 finishes.
- `clk` in 1: pixel clock (25.175 MHz). One clock only.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: one-cycle pulse at x==0, y==0 from the sync generator.
- `hold` in 1: while high, frame ticks are ignored.
- `skip` in 1: single-cycle request to end the current part early.
- `part` out 3: current part index.
- `part_frame` out 12: frames elapsed in the current part.
- `global_frame` out 12: frames since reset; wraps at 4096.
- `brightness` out 2: 0 is black, 3 is full. The renderer scales RGB by this value.
- `part_start` out 1: one-cycle pulse when a new part begins.
- `note_idx` out 3: `global_frame[7:5]`.
- `env_a` out 5: 31 − `global_frame[4:0]`.
- `env_b` out 5: 31 − 2·`global_frame[3:0]`.
- `beat13` out 1: `global_frame[5:4]` == 2'b10.

## Operation
- The part length ROM, in units, is {4,4,8,8,4,8,8,4} for parts 0..7.
  - `len_frames` = units << UNIT_LOG2, so part 0 is 128 frames.
  - Every entry must satisfy `len_frames` ≥ 7·FADE_STEP+1. Elaboration asserts this.
- A "tick" is `frame_tick` & ~`hold`. Nothing changes on cycles without a tick, except that `skip` is still sampled and `part_start` clears.
- On every tick: `global_frame`+1 and `part_frame`+1. The exception is the part advance below, where `part_frame` is set to 0.
- `fade_cnt` counts ticks from 0 to FADE_STEP−1. When it wraps, that tick is a "fade step". `fade_cnt` clears on every state entry.
- The FSM has three states: FADE_IN, PLAY, FADE_OUT.
  - **FADE_IN:** each fade step does `brightness`+1. The fade step that reaches 3 moves the FSM to PLAY.
  - **PLAY:** when a tick makes `part_frame` equal `len_frames` − 4·FADE_STEP, go to FADE_OUT.
  - **FADE_OUT:** each fade step does `brightness`−1 while `brightness` > 0. The fade step taken while `brightness` == 0 performs the part advance:
    - `part` ← `part`+1, or LOOP_PART if `part` == 7;
    - `part_frame` ← 0;
    - `part_start` ← 1 for one cycle;
    - go to FADE_IN.
- `skip` in FADE_IN or PLAY:
  - go to FADE_OUT, with `fade_cnt` ← 0 and `brightness` kept at its current value;
  - if it coincides with a tick, the tick's counter and brightness effects apply first, then skip overrides the tick's state transition.
- `skip` in FADE_OUT is ignored.
- Without a skip, a part lasts exactly `len_frames` ticks: the fade-out takes 4·FADE_STEP ticks and ends with the advance.
- Reset state:
  - FSM in FADE_IN;
  - `part`, `part_frame`, `global_frame`, `brightness`, `fade_cnt` and `part_start` all 0;
  - derived outputs are therefore `env_a`=31, `env_b`=31, `note_idx`=0, `beat13`=0.
- There is no `part_start` pulse at reset.
- Asserting reset mid-fade or mid-part aborts immediately to the reset state.

## Timing
- Registered outputs change on the clock edge that samples the tick, so they are visible the cycle after `frame_tick`.
- Derived outputs are combinational from the `global_frame` register. They add no extra latency.
- `part_start` is high for exactly one cycle, the same cycle in which `part_frame`=0 and the new `part` first appear.
- `global_frame` wraps from 4095 to 0 with no side effects. The part sequence is independent of this wrap.

## Structure
- Package `demo_seq_pkg` holds:
  - the state enum;
  - the part-length ROM as a function of the 3-bit part index;
  - the constants NUM_PARTS=8 and MAX_BRIGHT=3.
- One sub-module, `demo_seq_fade`, owns `fade_cnt` and `brightness`.
  - Inputs: tick, dir (up/down), restart.
  - Outputs: fade step, brightness.
  - The parent FSM uses it.

## Test plan
All scenarios use the default parameters.
- **Reset then 6 ticks:** `brightness` reads 0,1,1,2,2,3 after ticks 1..6 (it steps at ticks 2, 4, 6); state is PLAY at tick 6; `part_frame`=6.
- **Continue to tick 120:** FADE_OUT is entered with `part_frame`=120. `brightness` is 2/1/0 at ticks 122/124/126. At tick 128: `part`=1, `part_frame`=0, one-cycle `part_start`, `global_frame`=128.
- **Skip in PLAY:** pulse `skip` at `part_frame`=20 with `brightness`=3. `brightness` is 2/1/0 after 2/4/6 further ticks; the advance occurs at the 8th tick.
- **Hold:** hold high across 10 `frame_tick` pulses; all outputs are unchanged. After release, counting resumes from the same values.
- **Loop:** run 1536 ticks from reset. `part` goes 7→1 (LOOP_PART) at tick 1536, and `global_frame` = 1536.
- **Derived outputs:** at `global_frame`=0x25, expect `env_a`=26, `env_b`=21, `note_idx`=1, `beat13`=1.
- **Skip with tick in FADE_IN:** `skip` coincident with the tick that raises `brightness` to 3 gives `brightness`=3 and state FADE_OUT (not PLAY).

Source files
------------

// File: rtl/demo_seq_pkg.sv
// Shared types and constants for the demo show sequencer: FSM state encoding,
// the per-part length ROM and the brightness ceiling.
package demo_seq_pkg;

  typedef enum logic [1:0] {
    ST_FADE_IN  = 2'd0,
    ST_PLAY     = 2'd1,
    ST_FADE_OUT = 2'd2
  } state_e;

  localparam int         NUM_PARTS  = 8;
  localparam logic [1:0] MAX_BRIGHT = 2'd3;

  // Part lengths in units of 2^UNIT_LOG2 frames.
  function automatic logic [3:0] part_len_units(input logic [2:0] p);
    case (p)
      3'd0:    return 4'd4;
      3'd1:    return 4'd4;
      3'd2:    return 4'd8;
      3'd3:    return 4'd8;
      3'd4:    return 4'd4;
      3'd5:    return 4'd8;
      3'd6:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/demo_seq_fade.sv
// Brightness fader: divides ticks by FADE_STEP into fade steps and walks the
// brightness level up or down, saturating at 0 and MAX_BRIGHT.
module demo_seq_fade
  import demo_seq_pkg::*;
#(
  parameter int FADE_STEP = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       dir_up_i,
  input  logic       restart_i,
  output logic       step_o,
  output logic [1:0] brightness_o
);

  localparam int CW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    bright_q, bright_d;

  assign step_o       = tick_i && (cnt_q == CW'(FADE_STEP - 1));
  assign brightness_o = bright_q;

  // A restart only clears the divider; the brightness effect of a coincident
  // step still lands so the parent can switch state on that same tick.
  always_comb begin
    cnt_d    = cnt_q;
    bright_d = bright_q;
    if (tick_i) begin
      cnt_d = step_o ? '0 : cnt_q + 1'b1;
    end
    if (step_o) begin
      if (dir_up_i && (bright_q != MAX_BRIGHT)) begin
        bright_d = bright_q + 2'd1;
      end else if (!dir_up_i && (bright_q != 2'd0)) begin
        bright_d = bright_q - 2'd1;
      end
    end
    if (restart_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      bright_q <= 2'd0;
    end else begin
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
    end
  end

endmodule

// File: rtl/demo_sequencer.sv
// Frame-rate show controller: steps through ROM-defined visual parts with
// fade-out/fade-in at each boundary and derives music timing from frame count.
module demo_sequencer
  import demo_seq_pkg::*;
#(
  parameter int UNIT_LOG2 = 5,
  parameter int FADE_STEP = 2,
  parameter int LOOP_PART = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        hold,
  input  logic        skip,
  output logic [2:0]  part,
  output logic [11:0] part_frame,
  output logic [11:0] global_frame,
  output logic [1:0]  brightness,
  output logic        part_start,
  output logic [2:0]  note_idx,
  output logic [4:0]  env_a,
  output logic [4:0]  env_b,
  output logic        beat13,
  output state_e      dbg_state
);

  for (genvar gi = 0; gi < NUM_PARTS; gi++) begin : g_len_chk
    if ((int'(part_len_units(3'(gi))) << UNIT_LOG2) < 7 * FADE_STEP + 1) begin : g_bad
      $error("demo_sequencer: part %0d too short for the fade sequence", gi);
    end
  end

  state_e      state_q, state_d;
  logic [2:0]  part_q, part_d;
  logic [11:0] part_frame_q, part_frame_d;
  logic [11:0] global_frame_q, global_frame_d;
  logic        part_start_q, part_start_d;

  logic        tick, fade_step, fade_restart, fade_dir_up;
  logic [1:0]  bright;
  logic [11:0] len_frames, fade_out_at, pf_inc;

  assign tick        = frame_tick & ~hold;
  assign len_frames  = 12'(part_len_units(part_q)) << UNIT_LOG2;
  assign fade_out_at = len_frames - 12'(4 * FADE_STEP);
  assign pf_inc      = part_frame_q + 12'd1;
  assign fade_dir_up = (state_q != ST_FADE_OUT);

  demo_seq_fade #(.FADE_STEP(FADE_STEP)) u_fade (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tick_i      (tick),
    .dir_up_i    (fade_dir_up),
    .restart_i   (fade_restart),
    .step_o      (fade_step),
    .brightness_o(bright)
  );

  always_comb begin
    state_d        = state_q;
    part_d         = part_q;
    part_frame_d   = part_frame_q;
    global_frame_d = global_frame_q;
    part_start_d   = 1'b0;
    fade_restart   = 1'b0;
    if (tick) begin
      global_frame_d = global_frame_q + 12'd1;
      part_frame_d   = pf_inc;
    end
    unique case (state_q)
      ST_FADE_IN: begin
        if (fade_step && (bright == MAX_BRIGHT - 2'd1)) begin
          state_d      = ST_PLAY;
          fade_restart = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick && (pf_inc == fade_out_at)) begin
          state_d      = ST_FADE_OUT;
          fade_restart = 1'b1;
        end
      end
      ST_FADE_OUT: begin
        // The step taken while already black is the part boundary.
        if (fade_step && (bright == 2'd0)) begin
          part_d       = (part_q == 3'(NUM_PARTS - 1)) ? 3'(LOOP_PART) : part_q + 3'd1;
          part_frame_d = 12'd0;
          part_start_d = 1'b1;
          state_d      = ST_FADE_IN;
          fade_restart = 1'b1;
        end
      end
      default: begin
        state_d      = ST_FADE_IN;
        fade_restart = 1'b1;
      end
    endcase
    if (skip && (state_q != ST_FADE_OUT)) begin
      state_d      = ST_FADE_OUT;
      fade_restart = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_FADE_IN;
      part_q         <= 3'd0;
      part_frame_q   <= 12'd0;
      global_frame_q <= 12'd0;
      part_start_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      part_q         <= part_d;
      part_frame_q   <= part_frame_d;
      global_frame_q <= global_frame_d;
      part_start_q   <= part_start_d;
    end
  end

  assign part         = part_q;
  assign part_frame   = part_frame_q;
  assign global_frame = global_frame_q;
  assign brightness   = bright;
  assign part_start   = part_start_q;
  assign dbg_state    = state_q;

  assign note_idx = global_frame_q[7:5];
  assign env_a    = 5'd31 - global_frame_q[4:0];
  assign env_b    = 5'd31 - {global_frame_q[3:0], 1'b0};
  assign beat13   = (global_frame_q[5:4] == 2'b10);

endmodule

// File: tb/tb_demo_sequencer.sv
// Self-checking bench for demo_sequencer: table-driven checkpoints, a
// frame-level reference model feeding an expected queue, and skip corner cases.
module tb_demo_sequencer;
  import demo_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, hold, skip;
  logic [2:0]  part;
  logic [11:0] part_frame, global_frame;
  logic [1:0]  brightness;
  logic        part_start;
  logic [2:0]  note_idx;
  logic [4:0]  env_a, env_b;
  logic        beat13;
  state_e      dbg_state;

  always #5 clk = ~clk;

  demo_sequencer #(.UNIT_LOG2(5), .FADE_STEP(2), .LOOP_PART(1)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hold(hold), .skip(skip),
    .part(part), .part_frame(part_frame), .global_frame(global_frame),
    .brightness(brightness), .part_start(part_start), .note_idx(note_idx),
    .env_a(env_a), .env_b(env_b), .beat13(beat13), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  int m_part, m_pf, m_gf;
  bit m_start;

  typedef struct {
    int         n;
    logic [2:0] part;
    logic [11:0] pf;
    logic [1:0] br;
    state_e     st;
    logic       start;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_len(input int p);
    case (p)
      0, 1, 4, 7: return 128;
      default:    return 256;
    endcase
  endfunction

  function automatic int m_bright(input int pf, input int len);
    if (pf < 6) return pf / 2;
    if (pf >= len - 8) return 3 - (pf - (len - 8)) / 2;
    return 3;
  endfunction

  function automatic state_e m_state(input int pf, input int len);
    if (pf < 6) return ST_FADE_IN;
    if (pf >= len - 8) return ST_FADE_OUT;
    return ST_PLAY;
  endfunction

  function automatic logic [31:0] exp_word();
    int l;
    l = m_len(m_part);
    return {3'(m_part), 12'(m_pf), 12'(m_gf), 2'(m_bright(m_pf, l)), m_start,
            2'(m_state(m_pf, l))};
  endfunction

  function automatic logic [31:0] act_word();
    return {part, part_frame, global_frame, brightness, part_start, 2'(dbg_state)};
  endfunction

  function automatic logic [31:0] exp_derived(input int gf);
    logic [4:0] ea, eb;
    logic [2:0] ni;
    logic       bt;
    ea = 5'(31 - (gf % 32));
    eb = 5'(31 - 2 * (gf % 16));
    ni = 3'((gf / 32) % 8);
    bt = ((gf / 16) % 4) == 2;
    return {18'd0, ea, eb, ni, bt};
  endfunction

  function automatic logic [31:0] act_derived();
    return {18'd0, env_a, env_b, note_idx, beat13};
  endfunction

  task automatic model_tick(input bit hd);
    m_start = 1'b0;
    if (!hd) begin
      m_gf = (m_gf + 1) % 4096;
      m_pf++;
      if (m_pf == m_len(m_part)) begin
        m_part  = (m_part == 7) ? 1 : m_part + 1;
        m_pf    = 0;
        m_start = 1'b1;
      end
    end
  endtask

  // Random idle gap, then one frame_tick; returns at the negedge after the tick edge.
  task automatic apply_tick(input bit hd, input bit sk, input bit sb);
    logic [31:0] e;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("start_idle", {31'd0, part_start}, 32'd0);
    end
    if (sb) begin
      model_tick(hd);
      exp_q.push_back(exp_word());
    end
    frame_tick = 1'b1;
    hold       = hd;
    skip       = sk;
    @(negedge clk);
    frame_tick = 1'b0;
    hold       = 1'b0;
    skip       = 1'b0;
    if (sb) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_state", act_word(), e);
        check("sb_derived", act_derived(), exp_derived(m_gf));
        if (m_gf == 37) begin
          check("gf25_env_a", {27'd0, env_a}, 32'd26);
          check("gf25_env_b", {27'd0, env_b}, 32'd21);
          check("gf25_note", {29'd0, note_idx}, 32'd1);
          check("gf25_beat", {31'd0, beat13}, 32'd1);
        end
      end
    end
  endtask

  task automatic pulse_skip();
    @(negedge clk);
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
  endtask

  // Reset is held with frame_tick high to confirm reset wins over a tick.
  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    rst_n      = 1'b1;
    m_part = 0; m_pf = 0; m_gf = 0; m_start = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset();
    check("rst_part", {29'd0, part}, 32'd0);
    check("rst_pf", {20'd0, part_frame}, 32'd0);
    check("rst_gf", {20'd0, global_frame}, 32'd0);
    check("rst_bright", {30'd0, brightness}, 32'd0);
    check("rst_start", {31'd0, part_start}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_FADE_IN});
    check("rst_env_a", {27'd0, env_a}, 32'd31);
    check("rst_env_b", {27'd0, env_b}, 32'd31);
    check("rst_note", {29'd0, note_idx}, 32'd0);
    check("rst_beat", {31'd0, beat13}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] skip_br[8];
    rst_n = 1'b0; frame_tick = 1'b0; hold = 1'b0; skip = 1'b0;

    vecs[0]  = '{1,   3'd0, 12'd1,   2'd0, ST_FADE_IN,  1'b0};
    vecs[1]  = '{1,   3'd0, 12'd2,   2'd1, ST_FADE_IN,  1'b0};
    vecs[2]  = '{1,   3'd0, 12'd3,   2'd1, ST_FADE_IN,  1'b0};
    vecs[3]  = '{1,   3'd0, 12'd4,   2'd2, ST_FADE_IN,  1'b0};
    vecs[4]  = '{1,   3'd0, 12'd5,   2'd2, ST_FADE_IN,  1'b0};
    vecs[5]  = '{1,   3'd0, 12'd6,   2'd3, ST_PLAY,     1'b0};
    vecs[6]  = '{113, 3'd0, 12'd119, 2'd3, ST_PLAY,     1'b0};
    vecs[7]  = '{1,   3'd0, 12'd120, 2'd3, ST_FADE_OUT, 1'b0};
    vecs[8]  = '{1,   3'd0, 12'd121, 2'd3, ST_FADE_OUT, 1'b0};
    vecs[9]  = '{1,   3'd0, 12'd122, 2'd2, ST_FADE_OUT, 1'b0};
    vecs[10] = '{2,   3'd0, 12'd124, 2'd1, ST_FADE_OUT, 1'b0};
    vecs[11] = '{2,   3'd0, 12'd126, 2'd0, ST_FADE_OUT, 1'b0};
    vecs[12] = '{1,   3'd0, 12'd127, 2'd0, ST_FADE_OUT, 1'b0};
    vecs[13] = '{1,   3'd1, 12'd0,   2'd0, ST_FADE_IN,  1'b1};

    do_reset();
    check_reset();

    for (int i = 0; i < 14; i++) begin
      repeat (vecs[i].n) apply_tick(1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d_part", i), {29'd0, part}, {29'd0, vecs[i].part});
      check($sformatf("vec%0d_pf", i), {20'd0, part_frame}, {20'd0, vecs[i].pf});
      check($sformatf("vec%0d_bright", i), {30'd0, brightness}, {30'd0, vecs[i].br});
      check($sformatf("vec%0d_state", i), {30'd0, dbg_state}, {30'd0, vecs[i].st});
      check($sformatf("vec%0d_start", i), {31'd0, part_start}, {31'd0, vecs[i].start});
    end
    check("adv_gf", {20'd0, global_frame}, 32'd128);

    // Hold: ten ignored ticks, then counting resumes.
    repeat (10) apply_tick(1'b1, 1'b0, 1'b1);
    check("hold_pf", {20'd0, part_frame}, 32'd0);
    check("hold_gf", {20'd0, global_frame}, 32'd128);
    repeat (5) apply_tick(1'b0, 1'b0, 1'b1);
    check("resume_pf", {20'd0, part_frame}, 32'd5);
    check("resume_gf", {20'd0, global_frame}, 32'd133);

    // Reset mid fade-in, then a long run covering the loop and gf wrap.
    do_reset();
    check_reset();
    for (int t = 1; t <= 4100; t++) begin
      apply_tick(1'b0, 1'b0, 1'b1);
      if (t == 1535) check("loop_pre_part", {29'd0, part}, 32'd7);
      if (t == 1536) begin
        check("loop_part", {29'd0, part}, 32'd1);
        check("loop_gf", {20'd0, global_frame}, 32'd1536);
        check("loop_start", {31'd0, part_start}, 32'd1);
      end
      if (t == 4096) check("wrap_gf", {20'd0, global_frame}, 32'd0);
    end

    // Skip in PLAY, plus an ignored skip during the fade-out.
    do_reset();
    repeat (20) apply_tick(1'b0, 1'b0, 1'b0);
    check("skp_pf", {20'd0, part_frame}, 32'd20);
    check("skp_pre_bright", {30'd0, brightness}, 32'd3);
    check("skp_pre_state", {30'd0, dbg_state}, {30'd0, ST_PLAY});
    pulse_skip();
    check("skp_state", {30'd0, dbg_state}, {30'd0, ST_FADE_OUT});
    check("skp_bright", {30'd0, brightness}, 32'd3);
    skip_br[0] = 2'd3; skip_br[1] = 2'd2; skip_br[2] = 2'd2; skip_br[3] = 2'd1;
    skip_br[4] = 2'd1; skip_br[5] = 2'd0; skip_br[6] = 2'd0; skip_br[7] = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      apply_tick(1'b0, 1'b0, 1'b0);
      check($sformatf("skp_t%0d_bright", k), {30'd0, brightness}, {30'd0, skip_br[k-1]});
      check($sformatf("skp_t%0d_part", k), {29'd0, part}, 32'd0);
      if (k == 1) pulse_skip();
    end
    apply_tick(1'b0, 1'b0, 1'b0);
    check("skp_adv_part", {29'd0, part}, 32'd1);
    check("skp_adv_pf", {20'd0, part_frame}, 32'd0);
    check("skp_adv_start", {31'd0, part_start}, 32'd1);
    check("skp_adv_state", {30'd0, dbg_state}, {30'd0, ST_FADE_IN});

    // Skip coincident with the tick that completes the fade-in.
    do_reset();
    repeat (5) apply_tick(1'b0, 1'b0, 1'b0);
    apply_tick(1'b0, 1'b1, 1'b0);
    check("skt_bright", {30'd0, brightness}, 32'd3);
    check("skt_state", {30'd0, dbg_state}, {30'd0, ST_FADE_OUT});
    check("skt_pf", {20'd0, part_frame}, 32'd6);
    repeat (2) apply_tick(1'b0, 1'b0, 1'b0);
    check("skt_bright2", {30'd0, brightness}, 32'd2);

    // Skip mid fade-in keeps the partial brightness and fades from there.
    do_reset();
    repeat (2) apply_tick(1'b0, 1'b0, 1'b0);
    pulse_skip();
    check("ski_bright", {30'd0, brightness}, 32'd1);
    check("ski_state", {30'd0, dbg_state}, {30'd0, ST_FADE_OUT});
    repeat (2) apply_tick(1'b0, 1'b0, 1'b0);
    check("ski_bright0", {30'd0, brightness}, 32'd0);
    check("ski_part_pre", {29'd0, part}, 32'd0);
    repeat (2) apply_tick(1'b0, 1'b0, 1'b0);
    check("ski_part", {29'd0, part}, 32'd1);
    check("ski_start", {31'd0, part_start}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
